// File: rtl/mfcc_melbank_acc.sv
// Mel filterbank accumulator: each power bin is weighted into two adjacent
// triangular filters using ROM coefficients, then all filter energies are streamed out.
module mfcc_melbank_acc #(
  parameter int unsigned PWR_WIDTH = 16,
  parameter int unsigned NUM_BINS  = 256,
  parameter int unsigned NUM_FILT  = 20,
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pwr_valid,
  input  logic [PWR_WIDTH-1:0] pwr_data,
  input  logic                 pwr_last,
  output logic                 pwr_ready,
  output logic [8:0]           rom_addr,
  input  logic [7:0]           rom_rd_data,
  output logic                 mel_valid,
  input  logic                 mel_ready,
  output logic [4:0]           mel_idx,
  output logic [ACC_WIDTH-1:0] mel_data,
  output logic                 busy
);

  localparam int unsigned PROD_W = PWR_WIDTH + 9;
  localparam int unsigned SUM_W  = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 1;

  typedef enum logic [2:0] {IDLE, RD_W, RD_F, ACC, OUT} state_t;

  state_t                 state, state_d;
  logic [7:0]             bin_cnt;
  logic [7:0]             bin_q;
  logic [PWR_WIDTH-1:0]   p_q;
  logic                   last_q;
  logic [7:0]             w_q;
  logic [ACC_WIDTH-1:0]   acc [NUM_FILT];
  int unsigned            f_u;
  logic [PROD_W-1:0]      prod_lo;
  logic [PROD_W-1:0]      prod_hi;
  logic                   frame_end;
  logic                   out_last;

  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [PROD_W-1:0]    b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (|s[SUM_W-1:ACC_WIDTH]) return '1;
    return s[ACC_WIDTH-1:0];
  endfunction

  always_comb begin
    f_u       = {24'd0, rom_rd_data};
    prod_lo   = PROD_W'(p_q) * PROD_W'(w_q);
    prod_hi   = PROD_W'(p_q) * (PROD_W'(9'd256) - PROD_W'(w_q));
    frame_end = last_q || (bin_q == 8'(NUM_BINS - 1));
    out_last  = (mel_idx == 5'(NUM_FILT - 1));
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (pwr_valid) state_d = RD_W;
      RD_W:    state_d = RD_F;
      RD_F:    state_d = ACC;
      ACC:     state_d = frame_end ? OUT : IDLE;
      OUT:     if (mel_ready && out_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pwr_ready = (state == IDLE);
    busy      = (state != IDLE);
    mel_valid = (state == OUT);
    mel_data  = '0;
    if (state == OUT) begin
      for (int unsigned i = 0; i < NUM_FILT; i++) begin
        if (mel_idx == 5'(i)) mel_data = acc[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // ROM is synchronous: the address issued in one state yields data in the next,
  // so the weight lands in RD_F and the filter index is consumed directly in ACC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt  <= '0;
      bin_q    <= '0;
      p_q      <= '0;
      last_q   <= 1'b0;
      w_q      <= '0;
      rom_addr <= '0;
      mel_idx  <= '0;
      for (int unsigned i = 0; i < NUM_FILT; i++) acc[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pwr_valid) begin
            p_q      <= pwr_data;
            last_q   <= pwr_last;
            bin_q    <= bin_cnt;
            rom_addr <= {1'b0, bin_cnt};
          end
        end
        RD_W: rom_addr <= {1'b1, bin_q};
        RD_F: w_q <= rom_rd_data;
        ACC: begin
          for (int unsigned i = 0; i < NUM_FILT; i++) begin
            if (f_u == i)          acc[i] <= sat_add(acc[i], prod_lo);
            else if (f_u + 1 == i) acc[i] <= sat_add(acc[i], prod_hi);
          end
          if (frame_end) begin
            bin_cnt <= '0;
            mel_idx <= '0;
          end else begin
            bin_cnt <= bin_q + 8'd1;
          end
        end
        OUT: begin
          if (mel_ready) begin
            if (out_last) begin
              mel_idx <= '0;
              for (int unsigned i = 0; i < NUM_FILT; i++) acc[i] <= '0;
            end else begin
              mel_idx <= mel_idx + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mfcc_melbank_acc.sv
// Directed bench for mfcc_melbank_acc: per-frame filter-energy model fed from a ROM image,
// checked every output cycle against a 32-bit and a 24-bit accumulator instance.
module tb_mfcc_melbank_acc;

  logic        clk_tb = 1'b0;
  logic        tb_rst = 1'b0;
  logic        pwr_valid;
  logic [15:0] pwr_data;
  logic        pwr_last;
  logic        mel_ready;

  logic        pwr_ready, busy, mel_valid;
  logic [8:0]  rom_addr;
  logic [7:0]  rom_rd;
  logic [4:0]  mel_idx;
  logic [31:0] mel_data;

  logic        pwr_ready24, busy24, mel_valid24;
  logic [8:0]  rom_addr24;
  logic [7:0]  rom_rd24;
  logic [4:0]  mel_idx24;
  logic [23:0] mel_data24;

  logic [7:0]  rom [512];

  int total = 0;
  int bad   = 0;

  longint macc   [20];
  longint macc24 [20];
  int     mbin;
  longint qd[$];
  longint qd24[$];
  int     qi[$];

  always #5 clk_tb = ~clk_tb;

  always @(posedge clk_tb) begin
    rom_rd   <= rom[rom_addr];
    rom_rd24 <= rom[rom_addr24];
  end

  mfcc_melbank_acc dut (
    .clk(clk_tb), .rst_n(tb_rst),
    .pwr_valid(pwr_valid), .pwr_data(pwr_data), .pwr_last(pwr_last), .pwr_ready(pwr_ready),
    .rom_addr(rom_addr), .rom_rd_data(rom_rd),
    .mel_valid(mel_valid), .mel_ready(mel_ready), .mel_idx(mel_idx), .mel_data(mel_data),
    .busy(busy)
  );

  mfcc_melbank_acc #(.ACC_WIDTH(24)) dut24 (
    .clk(clk_tb), .rst_n(tb_rst),
    .pwr_valid(pwr_valid), .pwr_data(pwr_data), .pwr_last(pwr_last), .pwr_ready(pwr_ready24),
    .rom_addr(rom_addr24), .rom_rd_data(rom_rd24),
    .mel_valid(mel_valid24), .mel_ready(mel_ready), .mel_idx(mel_idx24), .mel_data(mel_data24),
    .busy(busy24)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic longint msat(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 20; i++) begin
      macc[i]   = 0;
      macc24[i] = 0;
    end
    mbin = 0;
  endtask

  // Energy model: bin b splits p between filter f (weight w/256) and f+1 ((256-w)/256).
  task automatic model_sample(input longint p, input bit last);
    int w, f;
    w = int'(rom[mbin]);
    f = int'(rom[256 + mbin]);
    if (f < 20) begin
      macc[f]   = msat(macc[f] + p * w, 32);
      macc24[f] = msat(macc24[f] + p * w, 24);
    end
    if (f + 1 < 20) begin
      macc[f+1]   = msat(macc[f+1] + p * (256 - w), 32);
      macc24[f+1] = msat(macc24[f+1] + p * (256 - w), 24);
    end
    if (last || mbin == 255) begin
      for (int i = 0; i < 20; i++) begin
        qd.push_back(macc[i]);
        qd24.push_back(macc24[i]);
        qi.push_back(i);
      end
      for (int i = 0; i < 20; i++) begin
        macc[i]   = 0;
        macc24[i] = 0;
      end
      mbin = 0;
    end else begin
      mbin++;
    end
  endtask

  always @(negedge clk_tb) begin
    if (tb_rst) begin
      chk("valid_match_24", longint'(mel_valid24), longint'(mel_valid));
      if (mel_valid) begin
        if (qd.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk("mel_idx", longint'(mel_idx), longint'(qi[0]));
          chk("mel_data", longint'(mel_data), qd[0]);
          chk("mel_idx24", longint'(mel_idx24), longint'(qi[0]));
          chk("mel_data24", longint'(mel_data24), qd24[0]);
          chk("pwr_ready_in_out", longint'(pwr_ready), 0);
          if (mel_ready) begin
            void'(qd.pop_front());
            void'(qd24.pop_front());
            void'(qi.pop_front());
          end
        end
      end
    end
  end

  task automatic set_bin(input int b, input int w, input int f);
    rom[b]       = 8'(w);
    rom[256 + b] = 8'(f);
  endtask

  task automatic send(input int p, input bit last);
    int n;
    n = 0;
    pwr_valid = 1'b1;
    pwr_data  = 16'(p);
    pwr_last  = last;
    while (!pwr_ready && n < 100) begin
      @(posedge clk_tb); #1;
      n++;
    end
    if (!pwr_ready) begin
      chk("send_timeout", 0, 1);
      pwr_valid = 1'b0;
    end else begin
      @(posedge clk_tb); #1;
      pwr_valid = 1'b0;
      pwr_last  = 1'b0;
      model_sample(longint'(p), last);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 400) begin
      @(posedge clk_tb); #1;
      n++;
    end
    chk("idle_reached", longint'(busy), 0);
    chk("queue_drained", longint'(qd.size()), 0);
  endtask

  task automatic do_reset();
    pwr_valid = 1'b0;
    pwr_last  = 1'b0;
    #2;
    tb_rst = 1'b0;
    model_clear();
    qd.delete();
    qd24.delete();
    qi.delete();
    @(posedge clk_tb); @(posedge clk_tb); #1;
    tb_rst = 1'b1;
  endtask

  task automatic single_bin_frame();
    for (int b = 0; b < 256; b++) set_bin(b, 0, 255);
    set_bin(0, 64, 3);
    send(100, 1'b1);
    chk("pin_acc3", qd[3], 6400);
    chk("pin_acc4", qd[4], 19200);
    @(posedge clk_tb); #1;
    @(posedge clk_tb); #1;
    chk("not_out_yet", longint'(mel_valid), 0);
    @(posedge clk_tb); #1;
    chk("out_after_4", longint'(mel_valid), 1);
    wait_idle();
  endtask

  initial begin
    longint sum;
    logic [31:0] hold_d;
    int n;
    pwr_valid = 1'b0;
    pwr_data  = '0;
    pwr_last  = 1'b0;
    mel_ready = 1'b1;
    for (int b = 0; b < 256; b++) set_bin(b, 0, 255);
    model_clear();
    @(posedge clk_tb); @(posedge clk_tb); #1;
    chk("rst_pwr_ready", longint'(pwr_ready), 1);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_mel_valid", longint'(mel_valid), 0);
    chk("rst_mel_idx", longint'(mel_idx), 0);
    chk("rst_mel_data", longint'(mel_data), 0);
    chk("rst_rom_addr", longint'(rom_addr), 0);
    tb_rst = 1'b1;
    @(posedge clk_tb); #1;

    single_bin_frame();

    // Top-edge filter: upper neighbour would be index 20 and must be dropped.
    for (int b = 0; b < 256; b++) set_bin(b, 0, 255);
    set_bin(0, 0, 19);
    send(1000, 1'b1);
    sum = 0;
    for (int i = 0; i < 20; i++) sum += qd[i];
    chk("pin_edge_sum", sum, 0);
    wait_idle();

    // Every bin skipped; frame closes at bin 255 without pwr_last.
    for (int b = 0; b < 256; b++) set_bin(b, 200, 255);
    for (int b = 0; b < 256; b++) send(16'hFFFF, 1'b0);
    chk("skip_frame_pushed", longint'(qd.size()), 20);
    @(posedge clk_tb); #1;
    @(posedge clk_tb); #1;
    chk("skip_not_out_yet", longint'(mel_valid), 0);
    @(posedge clk_tb); #1;
    chk("skip_out_entered", longint'(mel_valid), 1);
    wait_idle();

    for (int b = 0; b < 256; b++) set_bin(b, 255, 0);
    for (int b = 0; b < 256; b++) send(16'hFFFF, 1'b0);
    chk("pin_sat_acc0", qd[0], 64'hFEFF_0100);
    chk("pin_sat_acc1", qd[1], 64'h00FF_FF00);
    chk("pin_sat24_acc0", qd24[0], 64'h00FF_FFFF);
    wait_idle();

    // Distinct per-filter energies, with a downstream stall at index 7.
    for (int b = 0; b < 256; b++) set_bin(b, 0, 255);
    for (int b = 0; b < 12; b++) set_bin(b, (b * 37) % 256, b);
    for (int b = 0; b < 12; b++) send(100 * (b + 1) + 7, b == 11);
    n = 0;
    while (!(mel_valid && mel_idx == 5'd7) && n < 100) begin
      @(posedge clk_tb); #1;
      n++;
    end
    chk("reach_idx7", longint'(mel_idx), 7);
    mel_ready = 1'b0;
    hold_d = mel_data;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_tb); #1;
      chk("stall_idx", longint'(mel_idx), 7);
      chk("stall_data", longint'(mel_data), longint'(hold_d));
      chk("stall_pwr_ready", longint'(pwr_ready), 0);
    end
    mel_ready = 1'b1;
    @(posedge clk_tb); #1;
    chk("release_idx8", longint'(mel_idx), 8);
    wait_idle();

    // Abandon a partially accumulated frame with reset.
    for (int b = 0; b < 10; b++) send(500 + b, 1'b0);
    do_reset();
    chk("midrst_busy", longint'(busy), 0);
    single_bin_frame();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
